alarm_ctrl_multizone: RTL and testbench
=======================================

Name: alarm_ctrl_multizone

Overview:
- Parametrised next-generation home-security control FSM: N zone inputs, programmable exit/entry/alarm/lockout delays, wrong-code attempt counter with keypad lockout, fire override.
- Sits between the keypad/password checker, the sensor front end and the siren/indicator drivers.
- Exposes a one-hot state vector for the display/LED logic.

Parameters:
- N_ZONES, 4, number of intrusion zone inputs (1..16).
- INSTANT_MASK, 4'b0001, zones that skip the entry delay and go straight to ALARM (width N_ZONES).
- EXIT_DLY, 16, cycles in EXIT before ARMED (>=1).
- ENTRY_DLY, 8, cycles in ENTRY before ALARM (>=1).
- ALARM_TIME, 32, cycles the siren sounds before re-arm (>=1).
- MAX_TRIES, 3, consecutive wrong codes that trigger LOCK (>=1).
- LOCK_TIME, 64, cycles of keypad lockout (>=1).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- load, input, 1, advance enable; 0 freezes state, timer, counters and outputs.
- arm_req, input, 1, single-cycle arm request.
- pw_valid, input, 1, single-cycle strobe: a code has been entered.
- pw_ok, input, 1, code correct; qualified by pw_valid.
- fire, input, 1, fire/smoke detector level.
- zone_trip, input, N_ZONES, intrusion sensor levels.
- state_oh, output, 7, one-hot state {FIRE,LOCK,ALARM,ENTRY,ARMED,EXIT,IDLE}, bit0 = IDLE.
- siren, output, 1, siren drive.
- fire_alarm, output, 1, fire indicator.
- armed, output, 1, high in ARMED, ENTRY or ALARM.
- zone_latch, output, N_ZONES, sticky record of zones tripped while armed.
- fail_cnt, output, $clog2(MAX_TRIES+1), current count of consecutive wrong codes.
- arm_fault, output, 1, one-cycle pulse when an arm request is refused.

Behaviour:
- Reset (reset=0 at an edge): state IDLE, state_oh=7'b0000001, timer=0, fail_cnt=0, zone_latch=0, all other outputs 0. Reset overrides load.
- All outputs are registered or decoded from registered state only; no combinational input-to-output path.
- Timer: on entry to a timed state it loads DLY-1 and decrements each load=1 cycle. Expiry is timer==0, so a timed state lasts exactly DLY enabled cycles.
- Per-cycle event priority (load=1): fire > good code > wrong code > timer expiry > zone trip > arm_req.
- good = pw_valid&pw_ok; bad = pw_valid&~pw_ok.
- Any state except FIRE, with fire=1: go to FIRE.
- FIRE: siren=1, fire_alarm=1. Go to IDLE only when fire=0 and good. Keypad input is otherwise ignored; fail_cnt is unchanged.
- good in EXIT/ARMED/ENTRY/ALARM: go to IDLE and clear fail_cnt. good in IDLE only clears fail_cnt.
- bad in IDLE/EXIT/ARMED/ENTRY/ALARM: fail_cnt+1. If the new value equals MAX_TRIES, go to LOCK and clear fail_cnt; otherwise the state is unchanged.
- LOCK: siren=1, keypad ignored. On expiry go to ARMED.
- IDLE with arm_req:
  - If (zone_trip & ~INSTANT_MASK | zone_trip & INSTANT_MASK) != 0, i.e. any zone is open: stay in IDLE and pulse arm_fault for one cycle.
  - Otherwise go to EXIT and clear zone_latch.
- EXIT: zone trips are ignored; on expiry go to ARMED.
- ARMED: on any zone_trip bit, OR zone_trip into zone_latch. Then go to ALARM if (zone_trip&INSTANT_MASK)!=0, else go to ENTRY.
- ENTRY: further trips are ORed into zone_latch. An instant-zone trip goes to ALARM immediately; timer expiry also goes to ALARM.
- ALARM: siren=1, trips continue to latch. On expiry go to ARMED (siren off, zone_latch kept).
- arm_req outside IDLE is ignored, with no arm_fault.
- load=0: all registers hold. A pw_valid or arm_req strobe arriving while load=0 is lost.
- A return to IDLE keeps zone_latch until the next accepted arm.

Decomposition:
- Package alarm_pkg holds:
  - state encoding constants IDLE=0 … FIRE=6 (3-bit binary) and the state count 7;
  - the one-hot decode function.
- Sub-module sec_timer: loadable down counter with inputs load_val, ld, en and output zero, width $clog2(max delay).
- The state register uses the existing register block (en=load).

Test Plan:
- Reset, then arm_req with zones=0 → EXIT for exactly 16 cycles, then armed=1, state_oh=7'b0000100.
- ARMED, zone_trip=4'b0100 for 1 cycle → ENTRY; no code for 8 cycles → ALARM, siren=1, zone_latch=4'b0100; after 32 cycles → ARMED, siren=0.
- ARMED, zone_trip=4'b0001 (instant) → ALARM on the next edge; good code → IDLE, siren=0, fail_cnt=0.
- ENTRY, three bad codes (fail_cnt goes 1,2) → LOCK on the third, fail_cnt=0; a good code during LOCK is ignored; after 64 cycles → ARMED.
- arm_req with zone_trip=4'b1000 → stays IDLE, arm_fault high for exactly 1 cycle.
- ALARM with fire=1 and a good code in the same cycle → FIRE. Good code with fire=1 → stays FIRE. fire=0 then good code → IDLE.
- Mid-EXIT: load=0 for 5 cycles freezes the timer (EXIT lasts 21 cycles total). reset=0 mid-ALARM → IDLE and all outputs zero at the next edge.

Source files
------------

// File: rtl/alarm_ctrl_multizone_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the multizone alarm controller:
//   - state_t      : 3-bit binary state encoding, IDLE=0 .. FIRE=6
//   - N_STATES     : number of states, also the width of the one-hot vector
//   - state_onehot : binary state -> one-hot display vector (bit0 = IDLE)
//   - is_timed     : states that run the delay timer
//   - max_of4      : helper used to size the delay timer
// ---------------------------------------------------------------------------
package alarm_pkg;

    localparam int N_STATES = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXIT  = 3'd1,
        ST_ARMED = 3'd2,
        ST_ENTRY = 3'd3,
        ST_ALARM = 3'd4,
        ST_LOCK  = 3'd5,
        ST_FIRE  = 3'd6
    } state_t;

    function automatic logic [N_STATES-1:0] state_onehot(input state_t s);
        return N_STATES'(1) << s;
    endfunction

    function automatic logic is_timed(input state_t s);
        return (s == ST_EXIT) || (s == ST_ENTRY) || (s == ST_ALARM) || (s == ST_LOCK);
    endfunction

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/alarm_ctrl_multizone_if.sv
// ---------------------------------------------------------------------------
// alarm_ctrl_multizone_if
// Bundles the keypad, sensor and indicator signals of the alarm controller.
//   master : the surrounding system (keypad checker, sensors, LED/siren logic)
//   slave  : the alarm controller itself
// Inputs to the controller : load, arm_req, pw_valid, pw_ok, fire, zone_trip
// Outputs of the controller: state_oh, siren, fire_alarm, armed, zone_latch,
//                            fail_cnt, arm_fault
// ---------------------------------------------------------------------------
interface alarm_ctrl_multizone_if #(
    parameter int N_ZONES   = 4,
    parameter int MAX_TRIES = 3
);
    localparam int FCW = $clog2(MAX_TRIES + 1);

    logic               load;
    logic               arm_req;
    logic               pw_valid;
    logic               pw_ok;
    logic               fire;
    logic [N_ZONES-1:0] zone_trip;

    logic [6:0]         state_oh;
    logic               siren;
    logic               fire_alarm;
    logic               armed;
    logic [N_ZONES-1:0] zone_latch;
    logic [FCW-1:0]     fail_cnt;
    logic               arm_fault;

    modport master (
        output load, arm_req, pw_valid, pw_ok, fire, zone_trip,
        input  state_oh, siren, fire_alarm, armed, zone_latch, fail_cnt, arm_fault
    );

    modport slave (
        input  load, arm_req, pw_valid, pw_ok, fire, zone_trip,
        output state_oh, siren, fire_alarm, armed, zone_latch, fail_cnt, arm_fault
    );

endinterface

// File: rtl/alarm_ctrl_multizone_sec_timer.sv
// ---------------------------------------------------------------------------
// sec_timer
// Loadable down counter used for the exit, entry, alarm and lockout delays.
//   clk        : clock
//   reset      : synchronous active-low reset, clears the count
//   ld_i       : load load_val_i (takes precedence over counting)
//   en_i       : decrement enable; the count stops at zero
//   load_val_i : delay minus one, so a state lasts exactly the delay
//   zero_o     : count is zero (delay expired)
// ---------------------------------------------------------------------------
module sec_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Count down towards zero and park there until the next load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (ld_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alarm_ctrl_multizone.sv
// ---------------------------------------------------------------------------
// alarm_ctrl_multizone
// Home-security control FSM with N intrusion zones, exit/entry/alarm delays,
// wrong-code counter with keypad lockout and fire override.
//   clk   : clock, all updates on the rising edge
//   reset : synchronous active-low reset (overrides load)
//   bus   : slave side of alarm_ctrl_multizone_if
//           in : load (advance enable), arm_req, pw_valid, pw_ok, fire,
//                zone_trip
//           out: state_oh, siren, fire_alarm, armed, zone_latch, fail_cnt,
//                arm_fault -- all registered
// ---------------------------------------------------------------------------
module alarm_ctrl_multizone
    import alarm_pkg::*;
#(
    parameter int                 N_ZONES      = 4,
    parameter logic [N_ZONES-1:0] INSTANT_MASK = 4'b0001,
    parameter int                 EXIT_DLY     = 16,
    parameter int                 ENTRY_DLY    = 8,
    parameter int                 ALARM_TIME   = 32,
    parameter int                 MAX_TRIES    = 3,
    parameter int                 LOCK_TIME    = 64
) (
    input logic                  clk,
    input logic                  reset,
    alarm_ctrl_multizone_if.slave bus
);

    localparam int MAX_DLY = max_of4(EXIT_DLY, ENTRY_DLY, ALARM_TIME, LOCK_TIME);
    localparam int TW      = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
    localparam int FCW     = $clog2(MAX_TRIES + 1);

    state_t                state_q, state_d;
    logic [FCW-1:0]        fail_q, fail_d, fail_inc;
    logic [N_ZONES-1:0]    latch_q, latch_d;
    logic                  fault_q, fault_d;
    logic [N_STATES-1:0]   state_oh_q;
    logic                  siren_q, fire_alarm_q, armed_q;

    logic                  good, bad, any_zone, inst_zone, expired;
    logic                  timer_ld, timer_zero;
    logic [TW-1:0]         timer_val;

    assign good      = bus.pw_valid &  bus.pw_ok;
    assign bad       = bus.pw_valid & ~bus.pw_ok;
    assign any_zone  = (bus.zone_trip != '0);
    assign inst_zone = ((bus.zone_trip & INSTANT_MASK) != '0);
    assign expired   = timer_zero;
    assign fail_inc  = fail_q + FCW'(1);

    // Next-state decision. The if/else chain encodes the event priority:
    // fire, good code, wrong code, then the per-state timer/zone/arm events.
    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        latch_d = latch_q;
        fault_d = 1'b0;

        if (bus.fire && (state_q != ST_FIRE)) begin
            state_d = ST_FIRE;
        end else begin
            case (state_q)
                ST_FIRE: begin
                    if (!bus.fire && good) state_d = ST_IDLE;
                end
                ST_LOCK: begin
                    if (expired) state_d = ST_ARMED;
                end
                ST_IDLE, ST_EXIT, ST_ARMED, ST_ENTRY, ST_ALARM: begin
                    if (good) begin
                        fail_d  = '0;
                        state_d = ST_IDLE;
                    end else if (bad) begin
                        if (fail_inc == FCW'(MAX_TRIES)) begin
                            fail_d  = '0;
                            state_d = ST_LOCK;
                        end else begin
                            fail_d = fail_inc;
                        end
                    end else begin
                        case (state_q)
                            ST_IDLE: begin
                                if (bus.arm_req) begin
                                    if (any_zone) begin
                                        fault_d = 1'b1;
                                    end else begin
                                        state_d = ST_EXIT;
                                        latch_d = '0;
                                    end
                                end
                            end
                            ST_EXIT: begin
                                if (expired) state_d = ST_ARMED;
                            end
                            ST_ARMED: begin
                                if (any_zone) begin
                                    latch_d = latch_q | bus.zone_trip;
                                    state_d = inst_zone ? ST_ALARM : ST_ENTRY;
                                end
                            end
                            ST_ENTRY: begin
                                if (expired) begin
                                    state_d = ST_ALARM;
                                end else if (any_zone) begin
                                    latch_d = latch_q | bus.zone_trip;
                                    if (inst_zone) state_d = ST_ALARM;
                                end
                            end
                            default: begin
                                if (expired) state_d = ST_ARMED;
                                else         latch_d = latch_q | bus.zone_trip;
                            end
                        endcase
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The delay timer is reloaded only when a timed state is freshly entered.
    always_comb begin
        case (state_d)
            ST_EXIT:  timer_val = TW'(EXIT_DLY - 1);
            ST_ENTRY: timer_val = TW'(ENTRY_DLY - 1);
            ST_ALARM: timer_val = TW'(ALARM_TIME - 1);
            ST_LOCK:  timer_val = TW'(LOCK_TIME - 1);
            default:  timer_val = '0;
        endcase
    end

    assign timer_ld = bus.load && (state_d != state_q) && is_timed(state_d);

    sec_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .ld_i       (timer_ld),
        .en_i       (bus.load),
        .load_val_i (timer_val),
        .zero_o     (timer_zero)
    );

    // State and all outputs are registered together; the outputs are decoded
    // from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            fail_q       <= '0;
            latch_q      <= '0;
            fault_q      <= 1'b0;
            state_oh_q   <= state_onehot(ST_IDLE);
            siren_q      <= 1'b0;
            fire_alarm_q <= 1'b0;
            armed_q      <= 1'b0;
        end else if (bus.load) begin
            state_q      <= state_d;
            fail_q       <= fail_d;
            latch_q      <= latch_d;
            fault_q      <= fault_d;
            state_oh_q   <= state_onehot(state_d);
            siren_q      <= (state_d == ST_FIRE) || (state_d == ST_LOCK) || (state_d == ST_ALARM);
            fire_alarm_q <= (state_d == ST_FIRE);
            armed_q      <= (state_d == ST_ARMED) || (state_d == ST_ENTRY) || (state_d == ST_ALARM);
        end
    end

    assign bus.state_oh   = state_oh_q;
    assign bus.siren      = siren_q;
    assign bus.fire_alarm = fire_alarm_q;
    assign bus.armed      = armed_q;
    assign bus.zone_latch = latch_q;
    assign bus.fail_cnt   = fail_q;
    assign bus.arm_fault  = fault_q;

endmodule

// File: tb/tb_alarm_ctrl_multizone.sv
// ---------------------------------------------------------------------------
// tb_alarm_ctrl_multizone
// Directed bench for alarm_ctrl_multizone with a behavioural reference model
// (remaining-cycle counts per timed state) checked every cycle, plus literal
// expectations at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_alarm_ctrl_multizone;

    localparam int         NZ     = 4;
    localparam logic [3:0] INST   = 4'b0001;
    localparam int         EXITD  = 16;
    localparam int         ENTRYD = 8;
    localparam int         ALARMT = 32;
    localparam int         MAXT   = 3;
    localparam int         LOCKT  = 64;

    localparam int S_IDLE = 0, S_EXIT = 1, S_ARMED = 2, S_ENTRY = 3,
                   S_ALARM = 4, S_LOCK = 5, S_FIRE = 6;

    localparam logic [6:0] OH_IDLE  = 7'b0000001;
    localparam logic [6:0] OH_EXIT  = 7'b0000010;
    localparam logic [6:0] OH_ARMED = 7'b0000100;
    localparam logic [6:0] OH_ENTRY = 7'b0001000;
    localparam logic [6:0] OH_ALARM = 7'b0010000;
    localparam logic [6:0] OH_LOCK  = 7'b0100000;
    localparam logic [6:0] OH_FIRE  = 7'b1000000;

    logic clk;
    logic rstN;
    bit   checkEn;
    int   nCompared;
    int   nMismatched;

    int         mState;
    int         mLeft;
    int         mFail;
    logic [3:0] mLatch;
    bit         mFault;

    alarm_ctrl_multizone_if #(.N_ZONES(NZ), .MAX_TRIES(MAXT)) bus ();

    alarm_ctrl_multizone #(
        .N_ZONES      (NZ),
        .INSTANT_MASK (INST),
        .EXIT_DLY     (EXITD),
        .ENTRY_DLY    (ENTRYD),
        .ALARM_TIME   (ALARMT),
        .MAX_TRIES    (MAXT),
        .LOCK_TIME    (LOCKT)
    ) dut (
        .clk   (clk),
        .reset (rstN),
        .bus   (bus)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int durOf(input int s);
        case (s)
            S_EXIT:  return EXITD;
            S_ENTRY: return ENTRYD;
            S_ALARM: return ALARMT;
            S_LOCK:  return LOCKT;
            default: return 0;
        endcase
    endfunction

    // Reference model: each timed state holds a count of enabled cycles left.
    always @(posedge clk) begin : refModel
        int         s, prev, left, fl;
        logic [3:0] lt;
        bit         flt, good, bad, expd, anyZ, instZ;
        s = mState; left = mLeft; fl = mFail; lt = mLatch; flt = mFault;
        prev = s;
        if (!rstN) begin
            s = S_IDLE; left = 0; fl = 0; lt = '0; flt = 1'b0;
            prev = s;
        end else if (bus.load) begin
            good  = bus.pw_valid && bus.pw_ok;
            bad   = bus.pw_valid && !bus.pw_ok;
            anyZ  = (bus.zone_trip != '0);
            instZ = ((bus.zone_trip & INST) != '0);
            flt   = 1'b0;
            expd  = (left <= 1);
            if (left > 0) left = left - 1;
            if (bus.fire && s != S_FIRE) begin
                s = S_FIRE;
            end else if (s == S_FIRE) begin
                if (!bus.fire && good) s = S_IDLE;
            end else if (s == S_LOCK) begin
                if (expd) s = S_ARMED;
            end else if (good) begin
                fl = 0;
                s  = S_IDLE;
            end else if (bad) begin
                fl = fl + 1;
                if (fl == MAXT) begin
                    fl = 0;
                    s  = S_LOCK;
                end
            end else begin
                case (s)
                    S_IDLE: if (bus.arm_req) begin
                        if (anyZ) flt = 1'b1;
                        else begin s = S_EXIT; lt = '0; end
                    end
                    S_EXIT: if (expd) s = S_ARMED;
                    S_ARMED: if (anyZ) begin
                        lt = lt | bus.zone_trip;
                        s  = instZ ? S_ALARM : S_ENTRY;
                    end
                    S_ENTRY: if (expd) s = S_ALARM;
                             else if (anyZ) begin
                                 lt = lt | bus.zone_trip;
                                 if (instZ) s = S_ALARM;
                             end
                    default: if (expd) s = S_ARMED;
                             else lt = lt | bus.zone_trip;
                endcase
            end
            if (s != prev) left = durOf(s);
        end
        mState <= s; mLeft <= left; mFail <= fl; mLatch <= lt; mFault <= flt;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the reference model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model.state_oh",   32'(bus.state_oh),   32'(7'b1 << mState));
            checkOutput("model.siren",      32'(bus.siren),
                        32'(mState == S_FIRE || mState == S_LOCK || mState == S_ALARM));
            checkOutput("model.fire_alarm", 32'(bus.fire_alarm), 32'(mState == S_FIRE));
            checkOutput("model.armed",      32'(bus.armed),
                        32'(mState == S_ARMED || mState == S_ENTRY || mState == S_ALARM));
            checkOutput("model.zone_latch", 32'(bus.zone_latch), 32'(mLatch));
            checkOutput("model.fail_cnt",   32'(bus.fail_cnt),   32'(mFail));
            checkOutput("model.arm_fault",  32'(bus.arm_fault),  32'(mFault));
        end
    end

    // Drive one cycle of inputs, return at the following falling edge.
    task automatic applyStimulus(input logic ldV, input logic armV, input logic pvV,
                                 input logic pokV, input logic fireV, input logic [3:0] ztV);
        bus.load      = ldV;
        bus.arm_req   = armV;
        bus.pw_valid  = pvV;
        bus.pw_ok     = pokV;
        bus.fire      = fireV;
        bus.zone_trip = ztV;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    task automatic armFromIdle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(EXITD - 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        nMismatched++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nCompared = 0; nMismatched = 0; checkEn = 1'b0;
        rstN = 1'b0;
        bus.load = 1'b1; bus.arm_req = 1'b0; bus.pw_valid = 1'b0;
        bus.pw_ok = 1'b0; bus.fire = 1'b0; bus.zone_trip = '0;

        // Reset
        idle(2);
        checkOutput("reset.state_oh", 32'(bus.state_oh), 32'(OH_IDLE));
        checkOutput("reset.fail_cnt", 32'(bus.fail_cnt), 32'd0);
        checkOutput("reset.latch",    32'(bus.zone_latch), 32'd0);
        checkEn = 1'b1;
        rstN = 1'b1;

        // Arm with all zones closed: EXIT for 16 cycles, then ARMED
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("exit.enter", 32'(bus.state_oh), 32'(OH_EXIT));
        idle(EXITD - 1);
        checkOutput("exit.last", 32'(bus.state_oh), 32'(OH_EXIT));
        idle(1);
        checkOutput("exit.armed_oh", 32'(bus.state_oh), 32'(OH_ARMED));
        checkOutput("exit.armed",    32'(bus.armed), 32'd1);

        // Delayed zone -> ENTRY -> ALARM -> ARMED
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
        checkOutput("entry.enter", 32'(bus.state_oh), 32'(OH_ENTRY));
        idle(ENTRYD - 1);
        checkOutput("entry.last", 32'(bus.state_oh), 32'(OH_ENTRY));
        idle(1);
        checkOutput("alarm.oh",    32'(bus.state_oh), 32'(OH_ALARM));
        checkOutput("alarm.siren", 32'(bus.siren), 32'd1);
        checkOutput("alarm.latch", 32'(bus.zone_latch), 32'h4);
        idle(ALARMT - 1);
        checkOutput("alarm.last", 32'(bus.state_oh), 32'(OH_ALARM));
        idle(1);
        checkOutput("rearm.oh",    32'(bus.state_oh), 32'(OH_ARMED));
        checkOutput("rearm.siren", 32'(bus.siren), 32'd0);
        checkOutput("rearm.latch", 32'(bus.zone_latch), 32'h4);

        // Instant zone -> ALARM at once; good code -> IDLE
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        checkOutput("instant.oh",    32'(bus.state_oh), 32'(OH_ALARM));
        checkOutput("instant.latch", 32'(bus.zone_latch), 32'h5);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        checkOutput("disarm.oh",    32'(bus.state_oh), 32'(OH_IDLE));
        checkOutput("disarm.siren", 32'(bus.siren), 32'd0);
        checkOutput("disarm.latch", 32'(bus.zone_latch), 32'h5);

        // Three wrong codes in ENTRY -> LOCK; good code ignored; 64 cycles -> ARMED
        armFromIdle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
        checkOutput("lock.entry", 32'(bus.state_oh), 32'(OH_ENTRY));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("lock.fail1", 32'(bus.fail_cnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("lock.fail2", 32'(bus.fail_cnt), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("lock.oh",    32'(bus.state_oh), 32'(OH_LOCK));
        checkOutput("lock.fail0", 32'(bus.fail_cnt), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        checkOutput("lock.goodIgnored", 32'(bus.state_oh), 32'(OH_LOCK));
        idle(LOCKT - 2);
        checkOutput("lock.last", 32'(bus.state_oh), 32'(OH_LOCK));
        idle(1);
        checkOutput("lock.armed", 32'(bus.state_oh), 32'(OH_ARMED));

        // Arm refused with an open zone
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000);
        checkOutput("fault.oh",    32'(bus.state_oh), 32'(OH_IDLE));
        checkOutput("fault.pulse", 32'(bus.arm_fault), 32'd1);
        idle(1);
        checkOutput("fault.clear", 32'(bus.arm_fault), 32'd0);

        // Fire overrides a simultaneous good code; only fire=0 + good leaves FIRE
        armFromIdle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        checkOutput("fire.oh",   32'(bus.state_oh), 32'(OH_FIRE));
        checkOutput("fire.ind",  32'(bus.fire_alarm), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        checkOutput("fire.hold", 32'(bus.state_oh), 32'(OH_FIRE));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("fire.noCode", 32'(bus.state_oh), 32'(OH_FIRE));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        checkOutput("fire.exit", 32'(bus.state_oh), 32'(OH_IDLE));
        checkOutput("fire.indOff", 32'(bus.fire_alarm), 32'd0);

        // Freeze mid-EXIT: a lost wrong-code strobe while load=0, EXIT lasts 21 cycles
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        idle(5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("freeze.fail", 32'(bus.fail_cnt), 32'd0);
        idle(EXITD - 6);
        checkOutput("freeze.last", 32'(bus.state_oh), 32'(OH_EXIT));
        idle(1);
        checkOutput("freeze.armed", 32'(bus.state_oh), 32'(OH_ARMED));

        // Reset mid-ALARM
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        idle(3);
        rstN = 1'b0;
        idle(1);
        checkOutput("rst.oh",    32'(bus.state_oh), 32'(OH_IDLE));
        checkOutput("rst.siren", 32'(bus.siren), 32'd0);
        checkOutput("rst.armed", 32'(bus.armed), 32'd0);
        checkOutput("rst.latch", 32'(bus.zone_latch), 32'd0);
        rstN = 1'b1;
        idle(2);

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
